// File: rtl/xbar_phv_arbiter.sv
`default_nettype none
// =============================================================================
// xbar_phv_arbiter : round-robin share of one stage crossbar between ingress and
//                    recirculation PHVs, with source-tag FIFO and drain control
// Revision 1.0
// =============================================================================
module xbar_phv_arbiter #(
  parameter int PHV_LEN    = 2304,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            req0_phv,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] req0_act,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [PHV_LEN-1:0]            req1_phv,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] req1_act,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] act_out,
  output logic                          phv_out_valid,
  input  logic                          xbar_ready_in,
  input  logic                          alu_valid_in,
  output logic                          out_src_id,
  output logic                          out_src_valid,
  input  logic                          drain_req,
  output logic                          drained,
  output logic                          err_underflow,
  output logic [31:0]                   grant_cnt0,
  output logic [31:0]                   grant_cnt1
);

  localparam int          ACT_W    = ACT_LEN * C_NUM_PHVS;
  localparam int          AW       = $clog2(TAG_DEPTH);
  localparam logic [AW:0] FULL_CNT = TAG_DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [PHV_LEN-1:0]   phv_out_q, phv_out_d;
  logic [ACT_W-1:0]     act_out_q, act_out_d;
  logic                 phv_out_valid_q, phv_out_valid_d;
  logic                 out_src_id_q, out_src_id_d;
  logic                 out_src_valid_q, out_src_valid_d;
  logic                 err_underflow_q, err_underflow_d;
  logic [31:0]          grant_cnt0_q, grant_cnt0_d;
  logic [31:0]          grant_cnt1_q, grant_cnt1_d;
  logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          tag_cnt_q, tag_cnt_d;

  logic tag_full;
  logic tag_empty;
  logic issue_ok;
  logic winner;
  logic grant;
  logic pop;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    tag_full  = (tag_cnt_q == FULL_CNT);
    tag_empty = (tag_cnt_q == '0);
    issue_ok  = (state_q == ST_RUN) & xbar_ready_in & ~tag_full;
    if (req0_valid & req1_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1_valid;
    end
    grant      = issue_ok & (req0_valid | req1_valid);
    req0_ready = grant & ~winner;
    req1_ready = grant & winner;
    pop        = alu_valid_in & ~tag_empty;
  end

  always_comb begin
    phv_out_d       = phv_out_q;
    act_out_d       = act_out_q;
    phv_out_valid_d = grant;
    last_grant_d    = last_grant_q;
    grant_cnt0_d    = grant_cnt0_q;
    grant_cnt1_d    = grant_cnt1_q;
    if (grant) begin
      phv_out_d    = winner ? req1_phv : req0_phv;
      act_out_d    = winner ? req1_act : req0_act;
      last_grant_d = winner;
      if (winner) begin
        grant_cnt1_d = grant_cnt1_q + 32'd1;
      end else begin
        grant_cnt0_d = grant_cnt0_q + 32'd1;
      end
    end
  end

  // Source-tag FIFO; an ALU pulse with nothing outstanding is dropped and flagged.
  always_comb begin
    tag_mem_d       = tag_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    tag_cnt_d       = tag_cnt_q;
    out_src_id_d    = out_src_id_q;
    out_src_valid_d = pop;
    err_underflow_d = err_underflow_q | (alu_valid_in & tag_empty);
    if (grant) begin
      tag_mem_d[wr_ptr_q] = winner;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      out_src_id_d = tag_mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
    case ({grant, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) begin
          state_d = (tag_empty && !phv_out_valid_q && !grant) ? ST_DRAINED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tag_empty && !phv_out_valid_q) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      last_grant_q    <= 1'b1;
      phv_out_q       <= '0;
      act_out_q       <= '0;
      phv_out_valid_q <= 1'b0;
      out_src_id_q    <= 1'b0;
      out_src_valid_q <= 1'b0;
      err_underflow_q <= 1'b0;
      grant_cnt0_q    <= '0;
      grant_cnt1_q    <= '0;
      tag_mem_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      tag_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      phv_out_q       <= phv_out_d;
      act_out_q       <= act_out_d;
      phv_out_valid_q <= phv_out_valid_d;
      out_src_id_q    <= out_src_id_d;
      out_src_valid_q <= out_src_valid_d;
      err_underflow_q <= err_underflow_d;
      grant_cnt0_q    <= grant_cnt0_d;
      grant_cnt1_q    <= grant_cnt1_d;
      tag_mem_q       <= tag_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      tag_cnt_q       <= tag_cnt_d;
    end
  end

  assign phv_out       = phv_out_q;
  assign act_out       = act_out_q;
  assign phv_out_valid = phv_out_valid_q;
  assign out_src_id    = out_src_id_q;
  assign out_src_valid = out_src_valid_q;
  assign drained       = (state_q == ST_DRAINED);
  assign err_underflow = err_underflow_q;
  assign grant_cnt0    = grant_cnt0_q;
  assign grant_cnt1    = grant_cnt1_q;

endmodule
`default_nettype wire
